// File: rtl/audioqsys_leds_if.sv
// audioqsys_leds_if: Avalon-MM slave bus bundle for the LED PIO.
// The master drives the request fields; the slave returns registered readdata.
interface audioqsys_leds_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/audioqsys_leds.sv
// audioqsys_leds: Avalon-MM LED output PIO with atomic set/clear and live readback.
// Hardware blink engine is built only when AUDIOQSYS_LEDS_BLINK_EN is defined.
module audioqsys_leds #(
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned BLINK_DIV  = 25000000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  audioqsys_leds_if.slave       bus,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam int unsigned CNT_W      = 26;
  localparam logic [1:0]  ADDR_DATA  = 2'd0;
  localparam logic [1:0]  ADDR_SET   = 2'd1;
  localparam logic [1:0]  ADDR_CLEAR = 2'd2;
  localparam logic [1:0]  ADDR_BLINK = 2'd3;

  // Reject divider values the counter cannot represent or that make no blink.
  if (BLINK_DIV < 2 || BLINK_DIV > ((1 << CNT_W) - 1)) begin : g_bad_blink_div
    $error("audioqsys_leds: BLINK_DIV out of range 2..2^26-1");
  end

  logic                  w_wr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_live;
  logic [DATA_WIDTH-1:0] w_mask_rd;
  logic [DATA_WIDTH-1:0] w_rd_mux;
  logic [DATA_WIDTH-1:0] r_data_reg;
  logic [31:0]           r_readdata;

  assign w_wr    = bus.chipselect & ~bus.write_n;
  assign w_wdata = bus.writedata[DATA_WIDTH-1:0];

  // Programmed pattern: plain write, atomic OR-set, atomic AND-NOT-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_reg <= '0;
    end else if (w_wr) begin
      case (bus.address)
        ADDR_DATA:  r_data_reg <= w_wdata;
        ADDR_SET:   r_data_reg <= r_data_reg | w_wdata;
        ADDR_CLEAR: r_data_reg <= r_data_reg & ~w_wdata;
        default:    r_data_reg <= r_data_reg;
      endcase
    end
  end

`ifdef AUDIOQSYS_LEDS_BLINK_EN
  logic [DATA_WIDTH-1:0] r_blink_mask;
  logic [CNT_W-1:0]      r_blink_cnt;
  logic                  r_blink_phase;
  logic                  w_blink_wr;

  assign w_blink_wr = w_wr && (bus.address == ADDR_BLINK);

  // Free-running half-period counter; a BLINK write restarts it at phase 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_mask  <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_blink_wr) begin
      r_blink_mask  <= w_wdata;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + CNT_W'(1);
    end
  end

  assign w_live    = r_data_reg ^ (r_blink_mask & {DATA_WIDTH{r_blink_phase}});
  assign w_mask_rd = r_blink_mask;
`else
  assign w_live    = r_data_reg;
  assign w_mask_rd = '0;
`endif

  assign out_port = w_live;

  // Read mux sees pre-write state, so a same-cycle write returns the old value.
  always_comb begin
    w_rd_mux = '0;
    case (bus.address)
      ADDR_DATA:  w_rd_mux = r_data_reg;
      ADDR_SET:   w_rd_mux = w_live;
      ADDR_CLEAR: w_rd_mux = '0;
      ADDR_BLINK: w_rd_mux = w_mask_rd;
      default:    w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= 32'(w_rd_mux);
    end
  end

  assign bus.readdata = r_readdata;

endmodule

// File: doc/audioqsys_leds.md
Name: audioqsys_leds

Overview:
- Avalon-MM output PIO slave on the audioqsys fabric that drives 18 board LEDs.
- Complements the switch input port: the CPU writes the LED pattern, and can set or clear individual bits atomically.
- Optional hardware blink engine toggles selected LEDs at a fixed rate with no CPU involvement.
- Readback of both the programmed value and the live pin value is provided.

Parameters:
- DATA_WIDTH, 18, width of out_port and of every internal register.
- BLINK_DIV, 25000000, clk cycles per blink half-period (50 MHz clk gives 1 Hz blink). Legal range 2..2^26-1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- address  input  2  word address of the register.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe, qualified by chipselect.
- writedata  input  32  write data; bits [31:DATA_WIDTH] ignored.
- readdata  output  32  registered read data; bits [31:DATA_WIDTH] always 0.
- out_port  output  DATA_WIDTH  LED drive.

Behaviour:
- Reset (async assert, sync to clk on release): data_reg=0, blink_mask=0, blink_cnt=0, blink_phase=0, readdata=0, out_port=0.
- Write occurs on a clk edge when chipselect=1 and write_n=0. No wait states.
- Address 0 (DATA): write sets data_reg=writedata[17:0]. Read returns data_reg.
- Address 1 (SET): write sets data_reg |= writedata[17:0]. Read returns live out_port.
- Address 2 (CLEAR): write sets data_reg &= ~writedata[17:0]. Read returns 0.
- Address 3 (BLINK): write sets blink_mask=writedata[17:0], blink_cnt=0, blink_phase=0. Read returns blink_mask.
- readdata: updated every clk from the address mux, independent of chipselect. Read latency is 1 cycle.
- A read in the same cycle as a write to the same register returns the pre-write value.
- out_port = data_reg XOR (blink_mask AND {DATA_WIDTH{blink_phase}}). It is a combinational function of registers only, so a write is visible on out_port the cycle after the write edge.
- Blink counter:
  - blink_cnt increments every clk.
  - When blink_cnt==BLINK_DIV-1: blink_cnt wraps to 0 and blink_phase toggles.
  - Period of a blinking bit is 2*BLINK_DIV cycles.
  - A BLINK write overrides the counter update in the same cycle (counter reset has priority).
- DATA/SET/CLEAR writes do not disturb blink_cnt or blink_phase.
- Bits with blink_mask=1 show data_reg during phase 0 and its inverse during phase 1.
- blink_mask=0: the counter still free-runs; out_port equals data_reg.
- Reset mid-blink: all state returns to reset values immediately; out_port=0 while reset_n=0.

Optional Feature:
- Macro: AUDIOQSYS_LEDS_BLINK_EN.
- Defined: blink engine as described above.
- Undefined:
  - blink_mask, blink_cnt and blink_phase are not implemented.
  - Address 3 writes are ignored and reads return 0.
  - out_port = data_reg.
  - Address 1 read returns data_reg.
  - BLINK_DIV is unused.

Test Plan:
- Reset check: hold reset_n=0, toggle clk -> out_port=0x00000, readdata=0. Release reset, read address 0 -> readdata=0 one cycle after the address is applied.
- DATA/SET/CLEAR sequence: write 0x0F0F0 to addr 0, then 0x00005 to addr 1, then 0x000F0 to addr 2 -> out_port 0x0F0F0, 0x0F0F5, 0x0F005 respectively, each one cycle after its write. Read addr 0 -> 0x0F005.
- Width masking: write 0xFFFFFFFF to addr 0 -> out_port=0x3FFFF. Read addr 0 -> readdata=0x0003FFFF.
- Blink (BLINK_DIV=4, macro defined): data_reg=0x00001, write 0x00003 to addr 3 -> out_port=0x00001 for 4 cycles, 0x00002 for 4 cycles, then repeats. Addr 1 read follows the live value; addr 3 read=0x00003.
- Blink restart: write addr 3 mid-phase-1 -> out_port returns to data_reg the next cycle and holds for a full 4 cycles. Assert reset_n=0 mid-blink -> out_port=0 asynchronously.
- Macro undefined: write 0x00003 to addr 3 -> out_port unchanged, addr 3 read=0.
